// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared constants for the 7-segment scan driver.
//   Segment codes are active-high, bit0 = a .. bit6 = g.
//   SEG_DEC : glyphs for 0..9
//   SEG_HEX : glyphs for A,b,C,d,E,F (values 10..15)
//   SEG_BLANK : all segments off; no valid glyph encodes to this value,
//               so the top uses it to recognise an undisplayable value.
package seg7_pkg;

    typedef logic [6:0] seg_code_t;

    localparam seg_code_t SEG_BLANK = 7'b000_0000;

    // Element [k] is the glyph for value k.
    localparam logic [9:0][6:0] SEG_DEC = {
        7'b110_1111,  // 9
        7'b111_1111,  // 8
        7'b000_0111,  // 7
        7'b111_1101,  // 6
        7'b110_1101,  // 5
        7'b110_0110,  // 4
        7'b100_1111,  // 3
        7'b101_1011,  // 2
        7'b000_0110,  // 1
        7'b011_1111   // 0
    };

    // Element [k] is the glyph for value 10+k.
    localparam logic [5:0][6:0] SEG_HEX = {
        7'b111_0001,  // F
        7'b111_1001,  // E
        7'b101_1110,  // d
        7'b011_1001,  // C
        7'b111_1100,  // b
        7'b111_0111   // A
    };

endpackage

// File: rtl/seg7_encode.sv
// seg7_encode
//   Combinational digit value -> active-high segment code.
//   Ports:
//     value_i  [3:0]  digit value
//     hex_en_i        1 = show 10..15 as A..F, 0 = blank them
//     code_o   [6:0]  segment code (SEG_BLANK when not displayable)
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [3:0] value_i,
    input  logic       hex_en_i,
    output seg_code_t  code_o
);

    logic [2:0] hex_idx;

    assign hex_idx = 3'(value_i - 4'd10);

    always_comb begin
        code_o = SEG_BLANK;
        if (value_i <= 4'd9)
            code_o = SEG_DEC[value_i];
        else if (hex_en_i)
            code_o = SEG_HEX[hex_idx];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multiplexed 7-segment display driver. Cycles through N_DIGITS digits,
//   holding each for SCAN_DIV CE-qualified cycles, with registered outputs.
//   Optional blinking is compiled in when the macro SEG7_BLINK_EN is defined.
//   Parameters: N_DIGITS, SCAN_DIV, HEX, ACTIVE_LOW, BLINK_FRAMES
//   Ports:
//     CLK, CLR           clock, asynchronous active-high reset
//     CE                 clock enable for counters and output registers
//     load               captures digits/dp_in/blink_mask into shadow regs
//     digits             4 bits per digit, digit 0 in the low nibble
//     dp_in, blink_mask  per-digit decimal point and blink select
//     lzb                leading-zero blanking (live)
//     seg, dp, an        segment, decimal point, one-hot digit enable
//     frame_done         pulse in the CE cycle where the index wraps to 0
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int HEX          = 0,
    parameter int ACTIVE_LOW   = 0,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  CE,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  lzb,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic INV    = (ACTIVE_LOW != 0);
    localparam logic HEX_EN = (HEX != 0);

    logic [N_DIGITS-1:0][3:0] dig_q;
    logic [N_DIGITS-1:0]      dpin_q;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [6:0]               seg_q, seg_d;
    logic                     dp_q, dp_d;
    logic [N_DIGITS-1:0]      an_q, an_d;

    logic      scan_tc;
    seg_code_t cur_code;
    logic      upper_nz, lz_blank, blink_blank, blank;

    // Shadow registers: load is deliberately not CE-qualified.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            dig_q  <= '0;
            dpin_q <= '0;
        end else if (load) begin
            dig_q  <= digits;
            dpin_q <= dp_in;
        end
    end

    // Scan counter / digit index
    assign scan_tc    = (cnt_q == CNT_LAST);
    assign frame_done = CE && scan_tc && (idx_q == IDX_LAST);

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (CE) begin
            if (scan_tc) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Leading-zero blanking: current digit blanked when it and every
    // higher digit is zero; digit 0 always shows.
    always_comb begin
        upper_nz = 1'b0;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (IDX_W'(j) >= idx_q && dig_q[j] != 4'd0)
                upper_nz = 1'b1;
        end
    end

    assign lz_blank = lzb && (idx_q != '0) && !upper_nz;

`ifdef SEG7_BLINK_EN
    localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [N_DIGITS-1:0] bmask_q;
    logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
    logic                phase_on_q, phase_on_d;

    // Blink counter advances on frame_done, which already carries CE.
    always_comb begin
        blk_cnt_d  = blk_cnt_q;
        phase_on_d = phase_on_q;
        if (frame_done) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d  = '0;
                phase_on_d = !phase_on_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            bmask_q    <= '0;
            blk_cnt_q  <= '0;
            phase_on_q <= 1'b1;
        end else begin
            if (load)
                bmask_q <= blink_mask;
            blk_cnt_q  <= blk_cnt_d;
            phase_on_q <= phase_on_d;
        end
    end

    assign blink_blank = !phase_on_q && bmask_q[idx_q];
`else
    localparam int BLINK_FRAMES_UNUSED = BLINK_FRAMES;
    logic blink_mask_unused;
    assign blink_mask_unused = ^blink_mask;
    assign blink_blank       = 1'b0;
`endif

    seg7_encode u_enc (
        .value_i  (dig_q[idx_q]),
        .hex_en_i (HEX_EN),
        .code_o   (cur_code)
    );

    // A value with no glyph (10..15 with HEX=0) blanks the whole digit.
    assign blank = lz_blank || blink_blank || (cur_code == SEG_BLANK);

    always_comb begin
        seg_d = blank ? SEG_BLANK : cur_code;
        dp_d  = !blank && dpin_q[idx_q];
        an_d  = '0;
        if (!blank)
            an_d[idx_q] = 1'b1;
    end

    // Registers hold active-high form; polarity applied at the pins so
    // reset lands on the inactive level either way.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            seg_q <= '0;
            dp_q  <= 1'b0;
            an_q  <= '0;
        end else if (CE) begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q ^ {7{INV}};
    assign dp  = dp_q ^ INV;
    assign an  = an_q ^ {N_DIGITS{INV}};

endmodule
